// File: rtl/split3.sv
`default_nettype none
// ============================================================================
//  Module   : split3
//  Purpose  : Three-way deterministic packet splitter. Pops one packet at a
//             time from an ingress buffer and writes it to output a, b or c
//             according to a 2-bit select field; select 3 is dropped and
//             counted. A single hold entry gives one packet of buffering.
//  Revision : 1.0  initial release
// ============================================================================
module split3 #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_LSB    = 30,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_buffer_in_empty,
    output logic                  o_read_en,
    input  logic                  i_buffer_a_full,
    input  logic                  i_buffer_b_full,
    input  logic                  i_buffer_c_full,
    output logic [DATA_WIDTH-1:0] o_dout_a,
    output logic [DATA_WIDTH-1:0] o_dout_b,
    output logic [DATA_WIDTH-1:0] o_dout_c,
    output logic                  o_wen_a,
    output logic                  o_wen_b,
    output logic                  o_wen_c,
    output logic [CNT_WIDTH-1:0]  o_drop_count,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ROUTE = 2'd2
    } state_t;

    localparam logic [1:0] c_SEL_A    = 2'd0;
    localparam logic [1:0] c_SEL_B    = 2'd1;
    localparam logic [1:0] c_SEL_C    = 2'd2;
    localparam logic [1:0] c_SEL_DROP = 2'd3;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [1:0]            r_hold_sel;
    logic                  r_read_en;
    logic [DATA_WIDTH-1:0] r_dout_a;
    logic [DATA_WIDTH-1:0] r_dout_b;
    logic [DATA_WIDTH-1:0] r_dout_c;
    logic                  r_wen_a;
    logic                  r_wen_b;
    logic                  r_wen_c;
    logic [CNT_WIDTH-1:0]  r_drop_count;

    logic [1:0]            w_sel;
    logic                  w_target_full;
    logic                  w_can_retire;

    assign w_sel = i_din[SEL_LSB+1:SEL_LSB];

    // Full flag of the held packet's destination only; other ports never stall us.
    always_comb begin
        w_target_full = 1'b0;
        case (r_hold_sel)
            c_SEL_A: w_target_full = i_buffer_a_full;
            c_SEL_B: w_target_full = i_buffer_b_full;
            c_SEL_C: w_target_full = i_buffer_c_full;
            default: w_target_full = 1'b0;
        endcase
    end

    // A dropped packet retires unconditionally; a routed one only when its sink has room.
    assign w_can_retire = (r_hold_sel == c_SEL_DROP) || !w_target_full;

    // Control FSM with registered outputs; all state moves on the falling edge.
    always_ff @(negedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_hold       <= '0;
            r_hold_sel   <= 2'd0;
            r_read_en    <= 1'b0;
            r_dout_a     <= '0;
            r_dout_b     <= '0;
            r_dout_c     <= '0;
            r_wen_a      <= 1'b0;
            r_wen_b      <= 1'b0;
            r_wen_c      <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_wen_a <= 1'b0;
            r_wen_b <= 1'b0;
            r_wen_c <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!i_buffer_in_empty) begin
                        r_read_en <= 1'b1;
                        r_state   <= S_FETCH;
                    end else begin
                        r_read_en <= 1'b0;
                    end
                end
                S_FETCH: begin
                    r_read_en  <= 1'b0;
                    r_hold     <= i_din;
                    r_hold_sel <= w_sel;
                    r_state    <= S_ROUTE;
                end
                S_ROUTE: begin
                    if (w_can_retire) begin
                        case (r_hold_sel)
                            c_SEL_A: begin
                                r_dout_a <= r_hold;
                                r_wen_a  <= 1'b1;
                            end
                            c_SEL_B: begin
                                r_dout_b <= r_hold;
                                r_wen_b  <= 1'b1;
                            end
                            c_SEL_C: begin
                                r_dout_c <= r_hold;
                                r_wen_c  <= 1'b1;
                            end
                            default: begin
                                if (r_drop_count != {CNT_WIDTH{1'b1}}) begin
                                    r_drop_count <= r_drop_count + CNT_WIDTH'(1);
                                end
                            end
                        endcase
                        // Back-to-back fetch keeps throughput at one packet per two cycles.
                        if (!i_buffer_in_empty) begin
                            r_read_en <= 1'b1;
                            r_state   <= S_FETCH;
                        end else begin
                            r_state   <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_read_en <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign o_read_en    = r_read_en;
    assign o_dout_a     = r_dout_a;
    assign o_dout_b     = r_dout_b;
    assign o_dout_c     = r_dout_c;
    assign o_wen_a      = r_wen_a;
    assign o_wen_b      = r_wen_b;
    assign o_wen_c      = r_wen_c;
    assign o_drop_count = r_drop_count;
    assign o_busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_split3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_split3
//  Purpose  : Self-checking bench for split3. An ingress queue feeds the DUT;
//             per-destination expected queues and a saturating drop tally
//             form the reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_split3;

    logic        clk   = 1'b1;
    logic        rst   = 1'b0;
    logic [31:0] din   = 32'd0;
    logic        empty = 1'b1;
    logic        a_full = 1'b0;
    logic        b_full = 1'b0;
    logic        c_full = 1'b0;

    logic        rd_en, wen_a, wen_b, wen_c, busy;
    logic [31:0] dout_a, dout_b, dout_c;
    logic [15:0] drop;

    logic        rd_en2, wen_a2, wen_b2, wen_c2, busy2;
    logic [31:0] dout_a2, dout_b2, dout_c2;
    logic [1:0]  drop2;

    split3 u_dut (
        .clk(clk), .rst(rst), .i_din(din), .i_buffer_in_empty(empty),
        .o_read_en(rd_en), .i_buffer_a_full(a_full), .i_buffer_b_full(b_full),
        .i_buffer_c_full(c_full), .o_dout_a(dout_a), .o_dout_b(dout_b),
        .o_dout_c(dout_c), .o_wen_a(wen_a), .o_wen_b(wen_b), .o_wen_c(wen_c),
        .o_drop_count(drop), .o_busy(busy)
    );

    // Narrow-counter instance sharing all inputs, used for saturation.
    split3 #(.CNT_WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .i_din(din), .i_buffer_in_empty(empty),
        .o_read_en(rd_en2), .i_buffer_a_full(a_full), .i_buffer_b_full(b_full),
        .i_buffer_c_full(c_full), .o_dout_a(dout_a2), .o_dout_b(dout_b2),
        .o_dout_c(dout_c2), .o_wen_a(wen_a2), .o_wen_b(wen_b2), .o_wen_c(wen_c2),
        .o_drop_count(drop2), .o_busy(busy2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rd_cyc = 0;
    int wca = 0, wcb = 0, wcc = 0;
    int wen_total = 0;
    int exp_drop  = 0;
    int exp_drop2 = 0;

    logic [31:0] inq[$];
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] qc[$];
    logic [31:0] last_a = 32'd0, last_b = 32'd0, last_c = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: routing decided purely from the select field at push time.
    task automatic push(input logic [31:0] p);
        inq.push_back(p);
        empty = 1'b0;
        case (p[31:30])
            2'd0: qa.push_back(p);
            2'd1: qb.push_back(p);
            2'd2: qc.push_back(p);
            default: begin
                if (exp_drop < 65535) exp_drop++;
                if (exp_drop2 < 3) exp_drop2++;
            end
        endcase
    endtask

    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        #1;
        cyc++;
        if (rd_en) begin
            if (inq.size() > 0) din = inq.pop_front();
            rd_cyc = cyc;
        end
        empty = (inq.size() == 0);
        check("wen_onehot", 32'(int'(wen_a) + int'(wen_b) + int'(wen_c) > 1), 32'd0);
        if (wen_a) begin
            wca = cyc; wen_total++;
            check("a_pending", 32'(qa.size() != 0), 32'd1);
            if (qa.size() > 0) begin e = qa.pop_front(); check("dout_a", dout_a, e); last_a = e; end
        end else check("dout_a_hold", dout_a, last_a);
        if (wen_b) begin
            wcb = cyc; wen_total++;
            check("b_pending", 32'(qb.size() != 0), 32'd1);
            if (qb.size() > 0) begin e = qb.pop_front(); check("dout_b", dout_b, e); last_b = e; end
        end else check("dout_b_hold", dout_b, last_b);
        if (wen_c) begin
            wcc = cyc; wen_total++;
            check("c_pending", 32'(qc.size() != 0), 32'd1);
            if (qc.size() > 0) begin e = qc.pop_front(); check("dout_c", dout_c, e); last_c = e; end
        end else check("dout_c_hold", dout_c, last_c);
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || rd_en || inq.size() > 0) && n < 300) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(n < 300), 32'd1);
    endtask

    task automatic wait_read();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!rd_en && n < 20);
        check("read_timeout", 32'(rd_en), 32'd1);
    endtask

    initial begin
        int r0, wb, wt;
        logic [31:0] p;

        // Reset held low with a packet waiting: nothing may move.
        rst = 1'b0;
        push(32'h0000_0099);
        repeat (3) begin
            tick();
            check("rst_read_en", 32'(rd_en), 32'd0);
            check("rst_wen", 32'({wen_a, wen_b, wen_c}), 32'd0);
            check("rst_drop", 32'(drop), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        rst = 1'b1;
        tick();
        check("read_en_after_reset", 32'(rd_en), 32'd1);
        r0 = cyc;
        drain();
        check("reset_pkt_latency", 32'(wca - r0), 32'd2);

        // Routing to each port in order, two cycles apart.
        push(32'h0000_0011);
        push(32'h4000_0022);
        push(32'h8000_0033);
        drain();
        check("route_b_spacing", 32'(wcb - wca), 32'd2);
        check("route_c_spacing", 32'(wcc - wcb), 32'd2);

        // Backpressure on b holds the packet and blocks further fetches.
        b_full = 1'b1;
        push(32'h4000_0055);
        push(32'h0000_0066);
        wait_read();
        tick();
        tick();
        repeat (10) begin
            tick();
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_read_en", 32'(rd_en), 32'd0);
            check("bp_wen_b", 32'(wen_b), 32'd0);
        end
        b_full = 1'b0;
        tick();
        check("bp_release_wen_b", 32'(wen_b), 32'd1);
        wb = cyc;
        drain();
        check("bp_next_on_a", 32'(wca - wb), 32'd2);

        // Non-target full flags must not stall.
        a_full = 1'b1;
        b_full = 1'b1;
        push(32'h8000_0077);
        wait_read();
        r0 = cyc;
        tick();
        tick();
        check("nontarget_wen_c", 32'(wen_c), 32'd1);
        check("nontarget_latency", 32'(wcc - r0), 32'd2);
        a_full = 1'b0;
        b_full = 1'b0;
        drain();

        // Drops: counted, never written; narrow counter saturates.
        wt = wen_total;
        for (int i = 0; i < 5; i++) push(32'hC000_0000 + 32'(i));
        drain();
        check("drop_count", 32'(drop), 32'(exp_drop));
        check("drop_count_5", 32'(drop), 32'd5);
        check("drop_count_sat", 32'(drop2), 32'd3);
        check("drop_no_wen", 32'(wen_total - wt), 32'd0);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0 && inq.size() < 4) begin
                p = $urandom;
                push(p);
            end
            a_full = ($urandom_range(0, 3) == 0);
            b_full = ($urandom_range(0, 3) == 0);
            c_full = ($urandom_range(0, 3) == 0);
            tick();
        end
        a_full = 1'b0;
        b_full = 1'b0;
        c_full = 1'b0;
        drain();
        check("rand_drop", 32'(drop), 32'(exp_drop));
        check("rand_drop2", 32'(drop2), 32'(exp_drop2));
        check("rand_qa_empty", 32'(qa.size()), 32'd0);
        check("rand_qb_empty", 32'(qb.size()), 32'd0);
        check("rand_qc_empty", 32'(qc.size()), 32'd0);

        // Reset while a packet is stuck in ROUTE: it must vanish.
        c_full = 1'b1;
        push(32'h8000_0088);
        wait_read();
        tick();
        tick();
        check("mid_stalled_busy", 32'(busy), 32'd1);
        qa.delete(); qb.delete(); qc.delete(); inq.delete();
        last_a = 32'd0; last_b = 32'd0; last_c = 32'd0;
        exp_drop = 0; exp_drop2 = 0;
        rst = 1'b0;
        tick();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_read_en", 32'(rd_en), 32'd0);
        check("mid_rst_drop", 32'(drop), 32'd0);
        check("mid_rst_drop2", 32'(drop2), 32'd0);
        rst = 1'b1;
        c_full = 1'b0;
        wt = wen_total;
        repeat (6) tick();
        check("mid_no_write", 32'(wen_total - wt), 32'd0);
        check("mid_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
